proc_sequencer: RTL and testbench

Instruction-fetch and issue sequencer for the 8-bit processor core. It owns the program counter and drives the instruction-memory address. It captures each fetched instruction and hands it to the datapath with a valid/ready handshake, then waits for completion and applies sequential or branch PC updates. It also handles NOP and HALT opcodes locally and flags a hung execution with a watchdog. It sits between the instruction memory (combinational read) and the processor datapath.

---
 rtl/proc_sequencer.sv | 132 +++++++++++++
 tb/tb_proc_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_sequencer.sv
// Instruction fetch/issue sequencer. It owns the PC, offers fetched instructions to the
// datapath over a valid/ready handshake, and retires NOP/HALT locally with an EXEC watchdog.
module proc_sequencer #(
  parameter logic [7:0]  RESET_PC     = 8'h00,
  parameter logic [7:0]  NOP_OPCODE   = 8'h00,
  parameter logic [7:0]  HALT_OPCODE  = 8'hFF,
  parameter int unsigned EXEC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  output logic [7:0]  ins_address,
  input  logic [7:0]  ins_bus,
  output logic [7:0]  ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        exec_done,
  input  logic        br_taken,
  input  logic [7:0]  br_target,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  localparam bit         WD_ENABLE = (EXEC_TIMEOUT != 0);
  localparam logic [7:0] WD_LIMIT  = 8'(EXEC_TIMEOUT);

  logic [2:0]  state_reg, state_next;
  logic [7:0]  pc_reg, pc_next;
  logic [7:0]  ir_reg, ir_next;
  logic [7:0]  wd_reg, wd_next;
  logic [15:0] retired_reg, retired_next;
  logic        ir_valid_reg, busy_reg, halted_reg, fault_reg;
  logic [7:0]  pc_inc;

  assign pc_inc = pc_reg + 8'd1;

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    wd_next      = wd_reg;
    retired_next = retired_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start && !stop) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (ins_bus == HALT_OPCODE) begin
          state_next = ST_HALTED;
        end else if (ins_bus == NOP_OPCODE) begin
          pc_next      = pc_inc;
          retired_next = retired_reg + 16'd1;
        end else begin
          ir_next    = ins_bus;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ir_ready) begin
          state_next = ST_EXEC;
          wd_next    = 8'd0;
        end
      end
      ST_EXEC: begin
        // exec_done takes priority over a watchdog expiry in the same cycle
        if (exec_done) begin
          pc_next      = br_taken ? br_target : pc_inc;
          retired_next = retired_reg + 16'd1;
          state_next   = stop ? ST_IDLE : ST_FETCH;
        end else if (WD_ENABLE && (wd_reg + 8'd1 == WD_LIMIT)) begin
          state_next = ST_FAULT;
        end else if (WD_ENABLE) begin
          wd_next = wd_reg + 8'd1;
        end
      end
      ST_HALTED, ST_FAULT: begin
        if (start) begin
          pc_next    = RESET_PC;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_PC;
      ir_reg       <= 8'h00;
      wd_reg       <= 8'd0;
      retired_reg  <= 16'h0000;
      ir_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      halted_reg   <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      wd_reg       <= wd_next;
      retired_reg  <= retired_next;
      // status flags are decoded from the next state so they line up with state_reg
      ir_valid_reg <= (state_next == ST_ISSUE);
      busy_reg     <= (state_next == ST_FETCH) || (state_next == ST_ISSUE) ||
                      (state_next == ST_EXEC);
      halted_reg   <= (state_next == ST_HALTED) || (state_next == ST_FAULT);
      fault_reg    <= (state_next == ST_FAULT);
    end
  end

  assign ins_address = pc_reg;
  assign ir          = ir_reg;
  assign ir_valid    = ir_valid_reg;
  assign busy        = busy_reg;
  assign halted      = halted_reg;
  assign fault       = fault_reg;
  assign retired     = retired_reg;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: directed scenarios followed by random programs checked
// against a program-level interpreter of the instruction memory.
module tb_proc_sequencer;

  localparam logic [7:0] NOP  = 8'h00;
  localparam logic [7:0] HALT = 8'hFF;
  localparam logic [7:0] RST  = 8'h00;
  localparam int         TMO  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        ir_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic        br_taken = 1'b0;
  logic [7:0]  br_target = 8'h00;
  logic [7:0]  ins_address, ins_bus, ir;
  logic        ir_valid, busy, halted, fault;
  logic [15:0] retired;

  logic [7:0]  mem [256];
  int          n_vec = 0;
  int          n_err = 0;

  // program-level reference state
  logic [7:0]  m_pc;
  logic [15:0] m_ret;
  int          phase;
  int          exec_left;
  int          n;

  always #5 clk = ~clk;

  assign ins_bus = mem[ins_address];

  proc_sequencer #(
    .RESET_PC(RST), .NOP_OPCODE(NOP), .HALT_OPCODE(HALT), .EXEC_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .ins_address(ins_address), .ins_bus(ins_bus), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .exec_done(exec_done), .br_taken(br_taken),
    .br_target(br_target), .busy(busy), .halted(halted), .fault(fault),
    .retired(retired)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // NOPs retire without issue, so the model walks past them on its own
  task automatic skip_nops();
    while (mem[m_pc] == NOP) begin
      m_pc  = m_pc + 8'd1;
      m_ret = m_ret + 16'd1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;

    // reset values
    tick();
    chk("rst_addr", 16'(ins_address), 16'(RST));
    chk("rst_ir", 16'(ir), 16'h0000);
    chk("rst_valid", 16'(ir_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_fault", 16'(fault), 16'h0);
    chk("rst_retired", retired, 16'h0000);

    // one instruction then HALT
    mem[0] = 8'h12;
    mem[1] = HALT;
    reset_n = 1'b1;
    tick();
    ir_ready = 1'b1;
    pulse_start();
    chk("t1_fetch_busy", 16'(busy), 16'h1);
    chk("t1_fetch_addr", 16'(ins_address), 16'h0000);
    tick();
    chk("t1_issue_valid", 16'(ir_valid), 16'h1);
    chk("t1_issue_ir", 16'(ir), 16'h0012);
    tick();
    chk("t1_exec_valid", 16'(ir_valid), 16'h0);
    chk("t1_exec_ir", 16'(ir), 16'h0012);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("t1_pc_next", 16'(ins_address), 16'h0001);
    chk("t1_retired", retired, 16'h0001);
    tick();
    chk("t1_halted", 16'(halted), 16'h1);
    chk("t1_busy", 16'(busy), 16'h0);
    chk("t1_halt_addr", 16'(ins_address), 16'h0001);

    // restart, taken branch to 40 with stop raised in EXEC
    pulse_start();
    chk("t2_restart_pc", 16'(ins_address), 16'(RST));
    tick();
    tick();
    stop = 1'b1; exec_done = 1'b1; br_taken = 1'b1; br_target = 8'h40;
    tick();
    stop = 1'b0; exec_done = 1'b0; br_taken = 1'b0;
    chk("t2_br_pc", 16'(ins_address), 16'h0040);
    chk("t2_idle_busy", 16'(busy), 16'h0);
    chk("t2_idle_halted", 16'(halted), 16'h0);
    chk("t2_retired", retired, 16'h0002);
    tick();
    chk("t2_idle_hold", 16'(ins_address), 16'h0040);
    stop = 1'b1;
    pulse_start();
    stop = 1'b0;
    chk("t2_start_stop_ignored", 16'(busy), 16'h0);

    // not-taken branch, then a slow ir_ready and a branch to FE with stop
    mem[8'h40] = 8'h34;
    mem[8'h41] = 8'h12;
    pulse_start();
    chk("t3_resume_pc", 16'(ins_address), 16'h0040);
    tick();
    chk("t3_ir", 16'(ir), 16'h0034);
    tick();
    exec_done = 1'b1; br_taken = 1'b0; br_target = 8'h77; ir_ready = 1'b0;
    tick();
    exec_done = 1'b0;
    chk("t3_nt_pc", 16'(ins_address), 16'h0041);
    chk("t3_retired", retired, 16'h0003);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 16'(ir_valid), 16'h1);
      chk("t3_hold_ir", 16'(ir), 16'h0012);
      tick();
    end
    ir_ready = 1'b1;
    tick();
    chk("t3_exec_after_ready", 16'(ir_valid), 16'h0);
    chk("t3_exec_busy", 16'(busy), 16'h1);
    stop = 1'b1; exec_done = 1'b1; br_taken = 1'b1; br_target = 8'hFE;
    tick();
    stop = 1'b0; exec_done = 1'b0; br_taken = 1'b0;
    chk("t3_br_fe", 16'(ins_address), 16'h00FE);
    chk("t3_idle_busy", 16'(busy), 16'h0);

    // NOP wrap FE -> FF -> 00 (HALT)
    mem[8'hFE] = NOP;
    mem[8'hFF] = NOP;
    mem[0]     = HALT;
    pulse_start();
    chk("t4_pc_fe", 16'(ins_address), 16'h00FE);
    tick();
    chk("t4_pc_ff", 16'(ins_address), 16'h00FF);
    chk("t4_ret_5", retired, 16'h0005);
    tick();
    chk("t4_pc_00", 16'(ins_address), 16'h0000);
    chk("t4_ret_6", retired, 16'h0006);
    tick();
    chk("t4_halted", 16'(halted), 16'h1);
    chk("t4_halt_pc", 16'(ins_address), 16'h0000);
    chk("t4_halt_ret", retired, 16'h0006);

    // watchdog expiry after 4 EXEC cycles
    mem[0] = 8'h56;
    pulse_start();
    tick();
    tick();
    for (int k = 0; k < TMO; k++) begin
      chk("t5_no_fault_yet", 16'(fault), 16'h0);
      tick();
    end
    chk("t5_fault", 16'(fault), 16'h1);
    chk("t5_fault_halted", 16'(halted), 16'h1);
    chk("t5_fault_busy", 16'(busy), 16'h0);
    chk("t5_fault_pc", 16'(ins_address), 16'h0000);
    chk("t5_fault_ret", retired, 16'h0006);
    stop = 1'b1;
    pulse_start();
    stop = 1'b0;
    chk("t5_restart_fault", 16'(fault), 16'h0);
    chk("t5_restart_busy", 16'(busy), 16'h1);
    chk("t5_restart_pc", 16'(ins_address), 16'(RST));

    // exec_done on the last allowed cycle wins over the watchdog
    tick();
    tick();
    for (int k = 0; k < TMO - 1; k++) tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("t6_no_fault", 16'(fault), 16'h0);
    chk("t6_pc", 16'(ins_address), 16'h0001);
    chk("t6_ret", retired, 16'h0007);
    tick();
    chk("t6_halted", 16'(halted), 16'h1);

    // asynchronous reset in the middle of ISSUE
    ir_ready = 1'b0;
    pulse_start();
    tick();
    chk("t7_issue_valid", 16'(ir_valid), 16'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_rst_addr", 16'(ins_address), 16'(RST));
    chk("t7_rst_ir", 16'(ir), 16'h0000);
    chk("t7_rst_valid", 16'(ir_valid), 16'h0);
    chk("t7_rst_busy", 16'(busy), 16'h0);
    chk("t7_rst_halted", 16'(halted), 16'h0);
    chk("t7_rst_fault", 16'(fault), 16'h0);
    chk("t7_rst_retired", retired, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();

    // random programs against the interpreter
    m_ret = 16'h0000;
    for (int p = 0; p < 6; p++) begin
      n = $urandom_range(8, 30);
      for (int i = 0; i < n; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? NOP : 8'($urandom_range(1, 254));
      mem[n] = HALT;
      m_pc = RST;
      phase = 0;
      ir_ready = 1'b0;
      exec_done = 1'b0;
      pulse_start();
      for (int c = 0; c < 1500 && !halted; c++) begin
        if (phase == 2) begin
          chk("rand_pc_after_done", 16'(ins_address), 16'(m_pc));
          chk("rand_retired", retired, m_ret);
          phase = 0;
        end
        if (phase == 1) begin
          chk("rand_exec_valid", 16'(ir_valid), 16'h0);
          if (exec_left == 0) begin
            exec_done = 1'b1;
            br_taken  = ($urandom_range(0, 2) == 0);
            br_target = 8'($urandom_range(int'(m_pc) + 1, n));
            m_pc  = br_taken ? br_target : m_pc + 8'd1;
            m_ret = m_ret + 16'd1;
            phase = 2;
          end else begin
            exec_done = 1'b0;
            br_taken  = 1'($urandom);
            br_target = 8'($urandom);
            exec_left--;
          end
        end else begin
          exec_done = 1'($urandom);
          br_taken  = 1'($urandom);
          br_target = 8'($urandom);
          ir_ready  = ($urandom_range(0, 2) != 0);
          if (ir_valid && ir_ready) begin
            skip_nops();
            chk("rand_ir", 16'(ir), 16'(mem[m_pc]));
            chk("rand_issue_pc", 16'(ins_address), 16'(m_pc));
            phase = 1;
            exec_left = $urandom_range(0, TMO - 1);
          end
        end
        tick();
      end
      exec_done = 1'b0;
      skip_nops();
      chk("rand_halted", 16'(halted), 16'h1);
      chk("rand_fault", 16'(fault), 16'h0);
      chk("rand_halt_pc", 16'(ins_address), 16'(m_pc));
      chk("rand_final_ret", retired, m_ret);
      $display("program %0d: len %0d halted at %0h retired %0d", p, n, ins_address, retired);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
